// File: rtl/scoreboard_counted_if.sv
// Issue-stage <-> scoreboard bundle: operand ids and valids, score/clear
// requests, and the stall / pending / error results.
interface scoreboard_counted_if #(
    parameter int els_p       = 32,
    parameter int id_width_p  = $clog2(els_p),
    parameter int num_src_p   = 3,
    parameter int num_clear_p = 2
);
    logic [num_src_p*id_width_p-1:0]   src_id_i;
    logic [num_src_p-1:0]              op_reads_i;
    logic [id_width_p-1:0]             dest_id_i;
    logic                              op_writes_i;
    logic                              score_i;
    logic [num_clear_p-1:0]            clear_i;
    logic [num_clear_p*id_width_p-1:0] clear_id_i;
    logic                              dependency_o;
    logic [els_p-1:0]                  pending_o;
    logic                              error_o;

    // Handshake: no valid/ready pair. score_i and clear_i[p] are single-cycle
    // strobes accepted unconditionally on the rising clock edge; dependency_o
    // is the combinational stall answer for the operands presented this cycle.
    modport master (
        output src_id_i, op_reads_i, dest_id_i, op_writes_i,
        output score_i, clear_i, clear_id_i,
        input  dependency_o, pending_o, error_o
    );

    modport slave (
        input  src_id_i, op_reads_i, dest_id_i, op_writes_i,
        input  score_i, clear_i, clear_id_i,
        output dependency_o, pending_o, error_o
    );
endinterface

// File: rtl/scoreboard_counted.sv
// Counting register scoreboard: per-register outstanding-write counters,
// multi-port clears with same-cycle bypass into the stall decision, and a
// sticky error flag for counter underflow/overflow.
module scoreboard_counted #(
    parameter int els_p         = 32,
    parameter int id_width_p    = $clog2(els_p),
    parameter int num_src_p     = 3,
    parameter int num_clear_p   = 2,
    parameter int count_width_p = 3,
    parameter bit x0_tied_p     = 1'b1,
    parameter bit allow_waw_p   = 1'b1
) (
    input logic           clk_i,
    input logic           reset_n_i,
    scoreboard_counted_if.slave sb_if
);

    localparam int dec_width_lp = $clog2(num_clear_p + 1);
    // Arithmetic width wide enough for both the count and the clear tally,
    // plus one bit so cnt+1 and the underflow compare never wrap.
    localparam int aw_lp = ((count_width_p > dec_width_lp) ? count_width_p : dec_width_lp) + 1;
    localparam logic [aw_lp-1:0] max_lp = aw_lp'((1 << count_width_p) - 1);

    logic [count_width_p-1:0] r_cnt  [els_p];
    logic                     r_err;

    logic [count_width_p-1:0] w_eff  [els_p];
    logic [count_width_p-1:0] w_next [els_p];
    logic [dec_width_lp-1:0]  w_dec  [els_p];
    logic [els_p-1:0]         w_inc;
    logic [els_p-1:0]         w_under;
    logic [els_p-1:0]         w_over;
    logic [els_p-1:0]         w_pending;
    logic                     w_dep;

    // Per-register increment/decrement, bypassed effective count and next count.
    always_comb begin
        logic [aw_lp-1:0] w_cnt_x;
        logic [aw_lp-1:0] w_dec_x;
        logic [aw_lp-1:0] w_sum_x;
        w_cnt_x = '0;
        w_dec_x = '0;
        w_sum_x = '0;
        for (int r = 0; r < els_p; r++) begin
            w_inc[r] = sb_if.score_i && (sb_if.dest_id_i == id_width_p'(r))
                       && !(x0_tied_p && (r == 0));
            w_dec[r] = '0;
            for (int p = 0; p < num_clear_p; p++) begin
                if (sb_if.clear_i[p] &&
                    (sb_if.clear_id_i[p*id_width_p +: id_width_p] == id_width_p'(r))) begin
                    w_dec[r] = w_dec[r] + dec_width_lp'(1);
                end
            end
            w_cnt_x    = aw_lp'(r_cnt[r]);
            w_dec_x    = aw_lp'(w_dec[r]);
            w_under[r] = (w_dec_x > w_cnt_x);
            // Effective count floors at zero; it never exceeds r_cnt so it fits.
            w_eff[r]   = w_under[r] ? '0 : count_width_p'(w_cnt_x - w_dec_x);
            w_sum_x    = aw_lp'(w_eff[r]) + aw_lp'(w_inc[r]);
            w_over[r]  = (w_sum_x > max_lp);
            w_next[r]  = w_over[r] ? count_width_p'(max_lp) : count_width_p'(w_sum_x);
            w_pending[r] = (r_cnt[r] != '0);
        end
    end

    // Issue stall: RAW on any read slot, WAW on the destination, using the
    // clear-bypassed counts so a completing write releases the stall at once.
    always_comb begin
        logic [id_width_p-1:0] w_id;
        w_dep = 1'b0;
        w_id  = '0;
        for (int k = 0; k < num_src_p; k++) begin
            w_id = sb_if.src_id_i[k*id_width_p +: id_width_p];
            if (sb_if.op_reads_i[k] && (int'(w_id) < els_p) &&
                !(x0_tied_p && (w_id == '0))) begin
                if (w_eff[w_id] != '0) begin
                    w_dep = 1'b1;
                end
            end
        end
        if (sb_if.op_writes_i && (int'(sb_if.dest_id_i) < els_p) &&
            !(x0_tied_p && (sb_if.dest_id_i == '0))) begin
            if (allow_waw_p) begin
                if (aw_lp'(w_eff[sb_if.dest_id_i]) == max_lp) begin
                    w_dep = 1'b1;
                end
            end else begin
                if (w_eff[sb_if.dest_id_i] != '0) begin
                    w_dep = 1'b1;
                end
            end
        end
    end

    // Counter and sticky-error state; reset drops every outstanding count.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int r = 0; r < els_p; r++) begin
                r_cnt[r] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int r = 0; r < els_p; r++) begin
                r_cnt[r] <= w_next[r];
            end
            if ((|w_under) || (|w_over)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign sb_if.dependency_o = w_dep;
    assign sb_if.pending_o    = w_pending;
    assign sb_if.error_o      = r_err;

endmodule

// File: tb/tb_scoreboard_counted.sv
// Directed bench for scoreboard_counted: a vector table on the default
// configuration plus hand sequences on narrow-counter / x0-untied and
// no-WAW variants, all driven from one shared stimulus set.
module tb_scoreboard_counted;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] src_id;
    logic [2:0]  op_reads;
    logic [4:0]  dest_id;
    logic        op_writes;
    logic        score;
    logic [1:0]  clear;
    logic [9:0]  clear_id;

    int n_cmp  = 0;
    int n_fail = 0;

    // clock
    always #5 clk = ~clk;

    scoreboard_counted_if if_a ();
    scoreboard_counted_if if_b ();
    scoreboard_counted_if if_c ();

    assign if_a.src_id_i = src_id;   assign if_b.src_id_i = src_id;   assign if_c.src_id_i = src_id;
    assign if_a.op_reads_i = op_reads; assign if_b.op_reads_i = op_reads; assign if_c.op_reads_i = op_reads;
    assign if_a.dest_id_i = dest_id; assign if_b.dest_id_i = dest_id; assign if_c.dest_id_i = dest_id;
    assign if_a.op_writes_i = op_writes; assign if_b.op_writes_i = op_writes; assign if_c.op_writes_i = op_writes;
    assign if_a.score_i = score;     assign if_b.score_i = score;     assign if_c.score_i = score;
    assign if_a.clear_i = clear;     assign if_b.clear_i = clear;     assign if_c.clear_i = clear;
    assign if_a.clear_id_i = clear_id; assign if_b.clear_id_i = clear_id; assign if_c.clear_id_i = clear_id;

    // A: defaults (M=7, x0 tied, WAW allowed)
    scoreboard_counted u_a (.clk_i(clk), .reset_n_i(reset_n), .sb_if(if_a));
    // B: M=3, x0 untied, WAW allowed
    scoreboard_counted #(.count_width_p(2), .x0_tied_p(1'b0)) u_b (
        .clk_i(clk), .reset_n_i(reset_n), .sb_if(if_b));
    // C: M=7, x0 tied, no WAW
    scoreboard_counted #(.allow_waw_p(1'b0)) u_c (
        .clk_i(clk), .reset_n_i(reset_n), .sb_if(if_c));

    typedef struct {
        logic [14:0] src;
        logic [2:0]  rd;
        logic [4:0]  dst;
        logic        wr;
        logic        sc;
        logic [1:0]  clr;
        logic [9:0]  clr_id;
        logic        exp_dep;
        logic [31:0] exp_pend;
        logic        exp_err;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [14:0] pk(input logic [4:0] s0, input logic [4:0] s1,
                                       input logic [4:0] s2);
        return {s2, s1, s0};
    endfunction

    function automatic vec_t mk(input logic [14:0] s, input logic [2:0] rd,
                                input logic [4:0] d, input logic wr, input logic sc,
                                input logic [1:0] cl, input logic [9:0] cid,
                                input logic dep, input logic [31:0] pend, input logic err);
        vec_t v;
        v.src = s; v.rd = rd; v.dst = d; v.wr = wr; v.sc = sc;
        v.clr = cl; v.clr_id = cid; v.exp_dep = dep; v.exp_pend = pend; v.exp_err = err;
        return v;
    endfunction

    task automatic set_in(input logic [14:0] s, input logic [2:0] rd, input logic [4:0] d,
                          input logic wr, input logic sc, input logic [1:0] cl,
                          input logic [9:0] cid);
        src_id = s; op_reads = rd; dest_id = d; op_writes = wr;
        score = sc; clear = cl; clear_id = cid;
    endtask

    task automatic idle();
        set_in(15'd0, 3'd0, 5'd0, 1'b0, 1'b0, 2'd0, 10'd0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(15'd0,       3'b000, 5'd0, 1'b0, 1'b0, 2'b00, 10'd0,         1'b0, 32'h0,   1'b0);
        tbl[1]  = mk(15'd0,       3'b000, 5'd5, 1'b1, 1'b1, 2'b00, 10'd0,         1'b0, 32'h0,   1'b0);
        tbl[2]  = mk(pk(5, 0, 0), 3'b001, 5'd0, 1'b0, 1'b0, 2'b00, 10'd0,         1'b1, 32'h20,  1'b0);
        tbl[3]  = mk(pk(5, 0, 0), 3'b001, 5'd0, 1'b0, 1'b0, 2'b10, {5'd5, 5'd0},  1'b0, 32'h20,  1'b0);
        tbl[4]  = mk(pk(5, 0, 0), 3'b001, 5'd0, 1'b0, 1'b0, 2'b00, 10'd0,         1'b0, 32'h0,   1'b0);
        tbl[5]  = mk(15'd0,       3'b000, 5'd0, 1'b1, 1'b1, 2'b00, 10'd0,         1'b0, 32'h0,   1'b0);
        tbl[6]  = mk(pk(0, 0, 0), 3'b111, 5'd0, 1'b0, 1'b0, 2'b00, 10'd0,         1'b0, 32'h0,   1'b0);
        tbl[7]  = mk(15'd0,       3'b000, 5'd9, 1'b1, 1'b1, 2'b00, 10'd0,         1'b0, 32'h0,   1'b0);
        tbl[8]  = mk(15'd0,       3'b000, 5'd9, 1'b1, 1'b1, 2'b00, 10'd0,         1'b0, 32'h200, 1'b0);
        tbl[9]  = mk(pk(0, 0, 9), 3'b100, 5'd0, 1'b0, 1'b0, 2'b00, 10'd0,         1'b1, 32'h200, 1'b0);
        tbl[10] = mk(pk(0, 0, 9), 3'b100, 5'd0, 1'b0, 1'b0, 2'b11, {5'd9, 5'd9},  1'b0, 32'h200, 1'b0);
        tbl[11] = mk(15'd0,       3'b000, 5'd0, 1'b0, 1'b0, 2'b00, 10'd0,         1'b0, 32'h0,   1'b0);
        tbl[12] = mk(15'd0,       3'b000, 5'd9, 1'b1, 1'b1, 2'b00, 10'd0,         1'b0, 32'h0,   1'b0);
        tbl[13] = mk(15'd0,       3'b000, 5'd0, 1'b0, 1'b0, 2'b11, {5'd9, 5'd9},  1'b0, 32'h200, 1'b0);
        tbl[14] = mk(15'd0,       3'b000, 5'd0, 1'b0, 1'b0, 2'b00, 10'd0,         1'b0, 32'h0,   1'b1);
        tbl[15] = mk(pk(9, 0, 0), 3'b001, 5'd0, 1'b0, 1'b0, 2'b00, 10'd0,         1'b0, 32'h0,   1'b1);

        // reset state
        reset_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_pend_a", if_a.pending_o, 32'h0);
        chk("rst_pend_b", if_b.pending_o, 32'h0);
        chk("rst_err_a", {31'd0, if_a.error_o}, 32'h0);
        chk("rst_err_b", {31'd0, if_b.error_o}, 32'h0);

        // every id read/written right after reset: no stall anywhere
        for (int i = 0; i < 32; i++) begin
            set_in(pk(5'(i), 5'(i), 5'(i)), 3'b111, 5'(i), 1'b1, 1'b0, 2'b00, 10'd0);
            #1;
            chk($sformatf("rst_dep_a_id%0d", i), {31'd0, if_a.dependency_o}, 32'h0);
            chk($sformatf("rst_dep_b_id%0d", i), {31'd0, if_b.dependency_o}, 32'h0);
            chk($sformatf("rst_dep_c_id%0d", i), {31'd0, if_c.dependency_o}, 32'h0);
        end
        chk("rst_pend_c", if_c.pending_o, 32'h0);
        chk("rst_err_c", {31'd0, if_c.error_o}, 32'h0);
        @(negedge clk);

        // vector table on instance A
        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i].src, tbl[i].rd, tbl[i].dst, tbl[i].wr, tbl[i].sc,
                   tbl[i].clr, tbl[i].clr_id);
            #1;
            chk($sformatf("tbl%0d_dep", i), {31'd0, if_a.dependency_o}, {31'd0, tbl[i].exp_dep});
            chk($sformatf("tbl%0d_pend", i), if_a.pending_o, tbl[i].exp_pend);
            chk($sformatf("tbl%0d_err", i), {31'd0, if_a.error_o}, {31'd0, tbl[i].exp_err});
            @(negedge clk);
        end

        // sticky error cleared only by reset
        do_reset();
        #1;
        chk("err_after_reset_a", {31'd0, if_a.error_o}, 32'h0);
        chk("pend_after_reset_a", if_a.pending_o, 32'h0);

        // saturation on B (M=3)
        set_in(15'd0, 3'd0, 5'd7, 1'b1, 1'b1, 2'b00, 10'd0);
        repeat (3) @(negedge clk);
        set_in(15'd0, 3'd0, 5'd7, 1'b1, 1'b0, 2'b00, 10'd0);
        #1;
        chk("sat_dep_b", {31'd0, if_b.dependency_o}, 32'h1);
        chk("sat_pend_b", if_b.pending_o, 32'h80);
        chk("sat_dep_a", {31'd0, if_a.dependency_o}, 32'h0);
        set_in(15'd0, 3'd0, 5'd7, 1'b1, 1'b1, 2'b01, {5'd0, 5'd7});
        #1;
        chk("sat_bypass_dep_b", {31'd0, if_b.dependency_o}, 32'h0);
        @(negedge clk);
        set_in(15'd0, 3'd0, 5'd7, 1'b1, 1'b0, 2'b00, 10'd0);
        #1;
        chk("sat_hold_dep_b", {31'd0, if_b.dependency_o}, 32'h1);
        chk("sat_hold_err_b", {31'd0, if_b.error_o}, 32'h0);
        set_in(15'd0, 3'd0, 5'd7, 1'b1, 1'b1, 2'b00, 10'd0);
        @(negedge clk);
        idle();
        #1;
        chk("ovf_err_b", {31'd0, if_b.error_o}, 32'h1);
        chk("ovf_pend_b", if_b.pending_o, 32'h80);
        chk("ovf_err_a", {31'd0, if_a.error_o}, 32'h0);
        set_in(15'd0, 3'd0, 5'd7, 1'b1, 1'b0, 2'b00, 10'd0);
        #1;
        chk("ovf_dep_b", {31'd0, if_b.dependency_o}, 32'h1);

        // x0 tied vs untied
        do_reset();
        set_in(15'd0, 3'd0, 5'd0, 1'b1, 1'b1, 2'b00, 10'd0);
        @(negedge clk);
        set_in(pk(0, 0, 0), 3'b001, 5'd0, 1'b0, 1'b0, 2'b00, 10'd0);
        #1;
        chk("x0_pend_a", if_a.pending_o, 32'h0);
        chk("x0_pend_b", if_b.pending_o, 32'h1);
        chk("x0_dep_a", {31'd0, if_a.dependency_o}, 32'h0);
        chk("x0_dep_b", {31'd0, if_b.dependency_o}, 32'h1);
        chk("x0_dep_c", {31'd0, if_c.dependency_o}, 32'h0);

        // no-WAW on C, then reset beats a simultaneous score
        do_reset();
        set_in(15'd0, 3'd0, 5'd3, 1'b1, 1'b1, 2'b00, 10'd0);
        @(negedge clk);
        set_in(15'd0, 3'd0, 5'd3, 1'b1, 1'b0, 2'b00, 10'd0);
        #1;
        chk("waw_dep_c", {31'd0, if_c.dependency_o}, 32'h1);
        chk("waw_dep_a", {31'd0, if_a.dependency_o}, 32'h0);
        chk("waw_pend_c", if_c.pending_o, 32'h8);
        reset_n = 1'b0;
        set_in(15'd0, 3'd0, 5'd3, 1'b1, 1'b1, 2'b00, 10'd0);
        @(negedge clk);
        reset_n = 1'b1;
        set_in(15'd0, 3'd0, 5'd3, 1'b1, 1'b0, 2'b00, 10'd0);
        #1;
        chk("rst_score_pend_c", if_c.pending_o, 32'h0);
        chk("rst_score_dep_c", {31'd0, if_c.dependency_o}, 32'h0);
        chk("rst_score_err_c", {31'd0, if_c.error_o}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
